// File: rtl/audio_sample_reader_pkg.sv
// Shared types and defaults for the audio sample reader: FSM state encoding,
// default widths, and the stereo sample word layout.
package audio_sample_reader_pkg;

  // Default word-address width; matches the 32768-word on-chip sample memory.
  localparam int ASR_ADDR_W     = 15;
  // Default word-count width; must be able to hold 2^ASR_ADDR_W.
  localparam int ASR_LEN_W      = 16;
  // Default return-data buffer depth in words (power of two, >= 2).
  localparam int ASR_FIFO_DEPTH = 8;
  // Width of one stereo sample word.
  localparam int ASR_SAMPLE_W   = 32;

  // Transfer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Stereo sample word: left channel in the upper half, right in the lower.
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } sample_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : audio_sample_reader_pkg

// File: rtl/audio_sample_reader_fifo.sv
// Synchronous return-data FIFO with show-ahead output: the head word is
// visible on o_rd_data whenever o_empty is low, and i_rd_en pops it.
// A simultaneous push and pop leaves the occupancy unchanged. i_flush
// empties the buffer in one cycle.
module audio_sample_reader_fifo
  import audio_sample_reader_pkg::*;
#(
  parameter int DEPTH = ASR_FIFO_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  sample_t          i_wr_data,
  input  logic             i_rd_en,
  output sample_t          o_rd_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  sample_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Writes into a full buffer and reads from an empty one are dropped.
  assign w_push = i_wr_en && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_rd_en && (r_count != '0);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // r_count, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule : audio_sample_reader_fifo

// File: rtl/audio_sample_reader.sv
// Avalon-MM read master streaming stereo sample words, in address order, onto
// an Avalon-ST source. Reads are pipelined and credit-limited so that
// outstanding reads plus buffered words never exceed the FIFO depth.
// Optional build macro AUDIO_SAMPLE_READER_LOOP_EN adds a 'loop' input: when
// set at start, the address sequence repeats until stop.
module audio_sample_reader
  import audio_sample_reader_pkg::*;
#(
  parameter int ADDR_W     = ASR_ADDR_W,
  parameter int LEN_W      = ASR_LEN_W,
  parameter int FIFO_DEPTH = ASR_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
`ifdef AUDIO_SAMPLE_READER_LOOP_EN
  input  logic              loop,
`endif
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       aso_data,
  output logic              aso_valid,
  input  logic              aso_ready
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  // Control state
  state_e            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_loop;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_num;
  logic [LEN_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_rd_stall;

  // Datapath / credit signals
  logic              w_loop_in;
  logic              w_remaining;
  logic              w_credit_ok;
  logic              w_rd_req;
  logic              w_rd_accept;
  logic              w_rsp;
  logic              w_last_issue;
  logic              w_run_done;
  logic              w_drain_done;
  logic              w_aso_valid;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_fifo_flush;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  sample_t           w_fifo_rdata;

`ifdef AUDIO_SAMPLE_READER_LOOP_EN
  assign w_loop_in = loop;
`else
  assign w_loop_in = 1'b0;
`endif

  // Words still to issue in this pass over the buffer.
  assign w_remaining  = (r_issued != r_num);
  assign w_last_issue = ((r_issued + LEN_W'(1)) == r_num);

  // Reads in flight plus words already buffered must stay below the depth,
  // which guarantees every returning word has a free FIFO slot.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count})
                       < (CNT_W + 1)'(FIFO_DEPTH);

  // Read request: new reads only in RUN; a stalled read is held to completion
  // even after stop has moved the FSM to DRAIN.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rd_req = 1'b0;
    unique case (r_state)
      ST_RUN:   w_rd_req = r_rd_stall || (w_remaining && w_credit_ok);
      ST_DRAIN: w_rd_req = r_rd_stall;
      default:  w_rd_req = 1'b0;
    endcase
  end

  assign w_rd_accept = w_rd_req && !avm_waitrequest;
  assign avm_read    = w_rd_req;
  assign avm_address = r_base + r_issued[ADDR_W-1:0];

  // Responses are only meaningful while reads are in flight; anything seen
  // with nothing outstanding (e.g. just after reset) is ignored.
  assign w_rsp = avm_readdatavalid && (r_outstanding != '0);

  // Returning data is buffered only in RUN; DRAIN discards and flushes.
  assign w_fifo_wr    = w_rsp && (r_state == ST_RUN);
  assign w_fifo_flush = (r_state == ST_DRAIN);
  assign w_aso_valid  = (r_state == ST_RUN) && !w_fifo_empty;
  assign w_fifo_rd    = w_aso_valid && aso_ready;

  assign aso_valid = w_aso_valid;
  assign aso_data  = w_aso_valid ? w_fifo_rdata : '0;

  // One-shot completion: everything issued, returned and taken downstream.
  assign w_run_done   = !r_loop && !w_remaining && (r_outstanding == '0)
                        && w_fifo_empty;
  // Abort completion: no held read and nothing left in flight.
  assign w_drain_done = (r_outstanding == '0) && !w_rd_req;

  audio_sample_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_flush   (w_fifo_flush),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (sample_t'(avm_readdata)),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Outstanding-read counter: +1 on accept, -1 on response, both -> hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_rd_accept, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Issue counter and stall tracking; in loop mode the counter restarts at
  // the base address straight after the last word of a pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issued   <= '0;
      r_rd_stall <= 1'b0;
    end else begin
      r_rd_stall <= w_rd_req && avm_waitrequest;
      if (r_state == ST_IDLE) begin
        if (start) r_issued <= '0;
      end else if (w_rd_accept) begin
        if (r_loop && w_last_issue) r_issued <= '0;
        else                        r_issued <= r_issued + 1'b1;
      end
    end
  end

  // Transfer FSM with registered busy/done; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_loop  <= 1'b0;
      r_base  <= '0;
      r_num   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // start takes priority; stop has no effect while idle
          if (start) begin
            r_base <= base_addr;
            r_num  <= num_words;
            r_loop <= w_loop_in;
            if (num_words != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_run_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (stop) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule : audio_sample_reader

// File: tb/tb_audio_sample_reader.sv
// Self-checking bench for audio_sample_reader. The memory slave and stream
// sink are modelled here; expected addresses and words come from the plain
// rule word(i) = mem[(base + i) mod 2^15] with mem[a] = a * 0x00010001.
`timescale 1ns/1ps
module tb_audio_sample_reader;
  import audio_sample_reader_pkg::*;

  localparam int AW    = 15;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef AUDIO_SAMPLE_READER_LOOP_EN
  logic          loop_i = 1'b0;
`endif
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [31:0]   aso_data;
  logic          aso_valid;
  logic          aso_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int ovf   = 0;

  typedef struct { int addr; int due; } rsp_t;
  rsp_t rq[$];

  always #5 clk = ~clk;

  audio_sample_reader #(.ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .stop              (stop),
`ifdef AUDIO_SAMPLE_READER_LOOP_EN
    .loop              (loop_i),
`endif
    .base_addr         (base_addr),
    .num_words         (num_words),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .aso_data          (aso_data),
    .aso_valid         (aso_valid),
    .aso_ready         (aso_ready)
  );

  // A write into a full FIFO would mean the credit rule was broken.
  always @(posedge clk) begin
    if (reset_n && dut.w_fifo_wr && (int'(dut.w_fifo_count) == DEPTH)) ovf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int base, input int num, input bit lp, input int i);
    int k;
    k = (lp && num > 0) ? (i % num) : i;
    return 32'((base + k) % 32768);
  endfunction

  function automatic logic [31:0] exp_word(input int base, input int num, input bit lp, input int i);
    return exp_addr(base, num, lp, i) * 32'h0001_0001;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_read"},  32'(avm_read), 0);
    check({tag, "_addr"},  32'(avm_address), 0);
    check({tag, "_valid"}, 32'(aso_valid), 0);
    check({tag, "_data"},  aso_data, 0);
  endtask

  // stop_mode: 0 none, 1 stop once stop_after words were delivered (and also
  // pulse stop together with start), 2 stop while >=3 reads are in flight
  // and a read is being held off by waitrequest.
  task automatic run_xfer(input int base, input int num, input bit lp,
                          input int wait_pct, input int rdy_pct, input int hold_off,
                          input int stop_mode, input int stop_after,
                          input int rst_at, input int lat_max);
    int  n_iss = 0, n_out = 0, n_out_before, last_due = -1, budget, acc_after = 0;
    bit  fin = 0, stopped = 0, prev_stall = 0, prev_aso_stall = 0, had_pend = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_aso = '0;
    rsp_t          rsp;
    budget = 200 + hold_off + num * 40;
    base_addr = AW'(base);
    num_words = LW'(num);
`ifdef AUDIO_SAMPLE_READER_LOOP_EN
    loop_i = lp;
`endif
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      start = (c == 0);
      stop  = (stop_mode == 1 && c == 0);
      base_addr = AW'(base);
      // start while busy must be ignored: offer a different base
      if (c == 2 && num > 0) begin
        start = 1'b1;
        base_addr = AW'(base + 7);
      end

      if (rst_at >= 0 && c == rst_at) begin
        reset_n = 1'b0;
        start = 1'b0;
        avm_readdatavalid = 1'b0;
        #1;
        check_reset_values("midrst");
        rq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end

      // ---- observe state left by the previous rising edge
      if (c == 0) check("idle_read", 32'(avm_read), 0);
      if (c == 1 && num > 0) check("first_read", 32'(avm_read), 1);
      if (done) begin
        fin = 1;
        check("busy_at_done", 32'(busy), 0);
        check("read_at_done", 32'(avm_read), 0);
        if (num == 0) check("zero_len_lat", 32'(c), 1);
        if (stopped) begin
          check("drain_outst", 32'(rq.size()), 0);
          check("drain_accepts", 32'(acc_after), 32'(had_pend));
        end else begin
          check("words_out", 32'(n_out), 32'(num));
          check("reads_issued", 32'(n_iss), 32'(num));
        end
      end else if (c >= 1 && num > 0) begin
        check("busy", 32'(busy), 1);
      end
      if (prev_stall) begin
        check("read_hold", 32'(avm_read), 1);
        check("addr_hold", 32'(avm_address), 32'(prev_addr));
      end
      if (prev_aso_stall) begin
        check("aso_valid_hold", 32'(aso_valid), 1);
        check("aso_data_hold", aso_data, prev_aso);
      end
      if (stopped) check("valid_after_stop", 32'(aso_valid), 0);
      if (stopped && avm_read) check("no_new_read", 32'(prev_stall), 1);
      if (!stopped && !lp && avm_read && n_iss >= num) check("extra_read", 32'(avm_read), 0);
      if (c == hold_off && hold_off >= 20 && num > DEPTH && wait_pct == 0) begin
        check("bp_issued", 32'(n_iss), 32'(DEPTH));
        check("bp_read_idle", 32'(avm_read), 0);
      end

      // ---- stream sink
      aso_ready = (c >= hold_off) && (int'($urandom_range(99)) < rdy_pct);
      n_out_before = n_out;
      if (aso_valid && aso_ready) begin
        check("aso_data", aso_data, exp_word(base, num, lp, n_out));
        n_out++;
      end

      // ---- memory slave: command side
      avm_waitrequest = int'($urandom_range(99)) < wait_pct;
      if (stop_mode == 2 && !stopped && rq.size() >= 3 && avm_read) begin
        avm_waitrequest = 1'b1;
        stop = 1'b1;
      end
      if (avm_read && !avm_waitrequest) begin
        check("read_addr", 32'(avm_address), exp_addr(base, num, lp, n_iss));
        if (!stopped) check("credit", 32'((n_iss - n_out_before) < DEPTH), 1);
        else acc_after++;
        n_iss++;
        last_due = ((c + int'($urandom_range(lat_max, 1))) > last_due)
                   ? (c + int'($urandom_range(lat_max, 1))) : (last_due + 1);
        rq.push_back('{int'(avm_address), last_due});
      end

      if (stop_mode == 1 && !stopped && c > 0 && n_out >= stop_after) stop = 1'b1;
      if (stop && c > 0 && !stopped) begin
        stopped  = 1;
        had_pend = avm_read && avm_waitrequest;
      end
      prev_stall     = avm_read && avm_waitrequest;
      prev_addr      = avm_address;
      prev_aso_stall = aso_valid && !aso_ready && !stop;
      prev_aso       = aso_data;

      // ---- memory slave: response side, in order
      if (rq.size() > 0 && rq[0].due <= c) begin
        rsp = rq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'(rsp.addr) * 32'h0001_0001;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end
    end

    start = 1'b0;
    stop = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    aso_ready = 1'b0;
    if (rst_at < 0) check("done_seen", 32'(fin), 1);
    // a few idle cycles: no second done, no stray reads; stop while idle ignored
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      stop = (t == 0);
      check("idle_done", 32'(done), 0);
      check("idle_read_after", 32'(avm_read), 0);
      check("idle_busy", 32'(busy), 0);
    end
    stop = 1'b0;
    rq.delete();
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // single shot, slave latency 1, no stalls
    run_xfer(32'h10, 4, 0, 0, 100, 0, 0, 0, -1, 1);
    // backpressure: sink held off for 30 cycles
    run_xfer(32'h200, 20, 0, 0, 100, 30, 0, 0, -1, 1);
    // waitrequest 50%
    run_xfer(32'h300, 24, 0, 50, 100, 0, 0, 0, -1, 2);
    // address wrap at the top of memory
    run_xfer(32'h7FFE, 4, 0, 0, 100, 0, 0, 0, -1, 1);
    // zero length
    run_xfer(32'h40, 0, 0, 0, 100, 0, 0, 0, -1, 1);
    // abort with reads in flight and a stalled read
    run_xfer(32'h500, 40, 0, 0, 100, 0, 2, 0, -1, 5);
    // stop after some words with a slow sink; also start+stop together in idle
    run_xfer(32'h600, 30, 0, 30, 40, 0, 1, 6, -1, 3);
    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      run_xfer(int'($urandom_range(32767)), int'($urandom_range(40, 1)), 0,
               int'($urandom_range(60)), int'($urandom_range(100, 30)), 0, 0, 0, -1,
               int'($urandom_range(3, 1)));
    end
    // reset in the middle of a transfer, then a clean transfer afterwards
    run_xfer(32'h700, 50, 0, 20, 80, 0, 0, 0, 12, 2);
    run_xfer(32'h7FF0, 20, 0, 20, 80, 0, 0, 0, -1, 2);
`ifdef AUDIO_SAMPLE_READER_LOOP_EN
    // looping: addresses 0,1,2,0,1,2,... until stop after 10 words
    run_xfer(0, 3, 1, 0, 100, 0, 1, 10, -1, 1);
    run_xfer(32'h7FFF, 5, 1, 40, 70, 0, 1, 17, -1, 2);
`endif
    check("fifo_overflow", 32'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_audio_sample_reader
